matrix_row_fetcher: RTL and testbench

//  Read-side sequencer for the layer/row weight matrix storage. The load-side locator fills this storage.
//  On start, walks row_index 0..SIZE-1 of a layer and issues read requests, then buffers returned rows in a
//  2-entry FIFO and presents them on a valid/ready stream to the compute array. Sits between storage and PE array.

---
 rtl/matrix_row_fetcher.sv | 201 ++++++++++++++++++++
 tb/tb_matrix_row_fetcher.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : matrix_row_fetcher
// Description : Read-side sequencer for the layer/row weight storage. On a
//               start, it walks the rows of a layer and issues storage reads.
//               The returned rows go through a 2-entry FIFO and are presented
//               on a valid/ready stream with a row tag and a last flag.
//               Optional macro FETCHER_AUTO_ADVANCE_EN: stream every layer
//               from start_layer up to LAYERS-1 back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_row_fetcher #(
   parameter int SIZE   = 3,
   parameter int LAYERS = 4,
   parameter int DATA_W = 96
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [31:0]       start_layer_i,
   output logic              rd_en_o,
   output logic [31:0]       rd_layer_index_o,
   output logic [31:0]       rd_row_index_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [31:0]       out_row_o,
   output logic              out_last_o,
   output logic              layer_done_o,
   output logic              busy_o,
   output logic              cfg_err_o
);

   localparam logic [31:0] c_LAST_ROW   = 32'(SIZE - 1);
   localparam logic [31:0] c_LAYERS     = 32'(LAYERS);
`ifdef FETCHER_AUTO_ADVANCE_EN
   localparam logic [31:0] c_LAST_LAYER = 32'(LAYERS - 1);
`endif
   // FIFO entry layout: {row data, row tag, last flag}
   localparam int          c_ENTRY_W    = DATA_W + 33;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          layer_q, layer_d;
   logic [31:0]          row_q, row_d;
   logic                 inflight_q;
   logic [31:0]          inflight_row_q;
   logic                 inflight_last_q;
   logic [c_ENTRY_W-1:0] fifo_mem_q [2];
   logic                 wr_ptr_q;
   logic                 rd_ptr_q;
   logic [1:0]           count_q;
   logic                 cfg_err_q;
   logic                 layer_done_q;

   logic                 w_pop;
   logic                 w_push;
   logic                 w_issue;
   logic                 w_row_last;
   logic                 w_cfg_err_d;
   logic [2:0]           w_occupancy;
   logic [c_ENTRY_W-1:0] w_head;

   assign w_pop       = out_valid_o && out_ready_i;
   assign w_push      = inflight_q;
   assign w_row_last  = (row_q == c_LAST_ROW);
   // Slots committed after this edge: stored rows plus the read in flight,
   // minus the row leaving now. A new read is only issued if it will fit.
   assign w_occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
   assign w_head      = fifo_mem_q[rd_ptr_q];

   assign rd_en_o          = w_issue;
   assign rd_layer_index_o = layer_q;
   assign rd_row_index_o   = row_q;
   assign out_valid_o      = (count_q != 2'd0);
   assign out_data_o       = w_head[c_ENTRY_W-1:33];
   assign out_row_o        = w_head[32:1];
   assign out_last_o       = w_head[0];
   assign layer_done_o     = layer_done_q;
   assign busy_o           = (state_q != S_IDLE);
   assign cfg_err_o        = cfg_err_q;

   // Next-state, read issue and address counter update
   always_comb begin
      state_d     = state_q;
      layer_d     = layer_q;
      row_d       = row_q;
      w_issue     = 1'b0;
      w_cfg_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (start_layer_i < c_LAYERS) begin
                  state_d = S_FETCH;
                  layer_d = start_layer_i;
                  row_d   = '0;
               end else begin
                  w_cfg_err_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (w_occupancy < 3'd2) begin
               w_issue = 1'b1;
               if (w_row_last) begin
                  row_d = '0;
`ifdef FETCHER_AUTO_ADVANCE_EN
                  if (layer_q < c_LAST_LAYER) begin
                     layer_d = layer_q + 32'd1;
                  end else begin
                     state_d = S_DRAIN;
                  end
`else
                  state_d = S_DRAIN;
`endif
               end else begin
                  row_d = row_q + 32'd1;
               end
            end
         end
         S_DRAIN: begin
            if ((count_q == 2'd0) && !inflight_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state and address counters
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         row_q   <= row_d;
      end
   end

   // Track the read whose data returns next cycle, with its row tag
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         inflight_q      <= 1'b0;
         inflight_row_q  <= '0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q <= w_issue;
         if (w_issue) begin
            inflight_row_q  <= row_q;
            inflight_last_q <= w_row_last;
         end
      end
   end

   // Two-entry row FIFO; push and pop may coincide
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < 2; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {rd_data_i, inflight_row_q, inflight_last_q};
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (w_push && !w_pop) begin
            count_q <= count_q + 2'd1;
         end else if (!w_push && w_pop) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

   // Single-cycle status pulses
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cfg_err_q    <= 1'b0;
         layer_done_q <= 1'b0;
      end else begin
         cfg_err_q    <= w_cfg_err_d;
         layer_done_q <= w_pop && w_head[0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_row_fetcher
// Description : Self-checking bench for matrix_row_fetcher. Expected reads
//               and output rows are queued when a start is driven and are
//               popped as the DUT issues reads and hands rows over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_row_fetcher;

   localparam int SIZE   = 3;
   localparam int LAYERS = 4;
   localparam int DATA_W = 96;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [31:0]       row;
      logic              last;
   } out_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic [31:0]       start_layer;
   logic              rd_en;
   logic [31:0]       rd_layer;
   logic [31:0]       rd_row;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [31:0]       out_row;
   logic              out_last;
   logic              layer_done;
   logic              busy;
   logic              cfg_err;

   logic [63:0]       exp_rd[$];
   out_t              exp_out[$];

   int                n_vec  = 0;
   int                n_err  = 0;
   int                n_rd   = 0;
   int                n_pop  = 0;
   int                n_done = 0;
   int                n_cfg  = 0;
   logic              hold_q = 1'b0;
   logic [DATA_W-1:0] hold_data;
   logic [31:0]       hold_row;

   matrix_row_fetcher #(
      .SIZE   (SIZE),
      .LAYERS (LAYERS),
      .DATA_W (DATA_W)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .start_i          (start),
      .start_layer_i    (start_layer),
      .rd_en_o          (rd_en),
      .rd_layer_index_o (rd_layer),
      .rd_row_index_o   (rd_row),
      .rd_data_i        (rd_data),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_data_o       (out_data),
      .out_row_o        (out_row),
      .out_last_o       (out_last),
      .layer_done_o     (layer_done),
      .busy_o           (busy),
      .cfg_err_o        (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] row_word(input logic [31:0] l, input logic [31:0] r);
      return {l ^ 32'hA5C3_0F00, r ^ 32'h5A00_3C00, (l << 8) + r + 32'h1234_0000};
   endfunction

   // Storage model: data one cycle after a read, junk otherwise
   always @(posedge clk) begin
      if (rd_en) rd_data <= row_word(rd_layer, rd_row);
      else       rd_data <= {$urandom, $urandom, $urandom};
   end

   task automatic push_layer(input logic [31:0] l);
      for (int r = 0; r < SIZE; r++) begin
         exp_rd.push_back({l, 32'(r)});
         exp_out.push_back('{data: row_word(l, 32'(r)), row: 32'(r), last: (r == SIZE - 1)});
      end
   endtask

   // Check the current cycle against the scoreboard, then advance one cycle
   task automatic tick();
      logic [63:0] e_rd;
      out_t        e_o;
      #1;
      if (rd_en) begin
         n_vec++;
         n_rd++;
         if (exp_rd.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got layer %0d row %0d, expected no read", rd_layer, rd_row);
         end else begin
            e_rd = exp_rd.pop_front();
            if ({rd_layer, rd_row} !== e_rd)
               begin n_err++; $display("FAIL rd_addr: got %h expected %h", {rd_layer, rd_row}, e_rd); end
         end
      end
      if (out_valid && out_ready) begin
         n_vec++;
         n_pop++;
         if (exp_out.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got row %0d data %h, expected nothing", out_row, out_data);
         end else begin
            e_o = exp_out.pop_front();
            if ({out_data, out_row, out_last} !== e_o)
               begin n_err++; $display("FAIL out_row: got %h expected %h", {out_data, out_row, out_last}, e_o); end
         end
      end
      if (hold_q) begin
         n_vec++;
         if (!out_valid || out_data !== hold_data || out_row !== hold_row)
            begin n_err++; $display("FAIL out_hold: got v%0b row %0d data %h expected row %0d data %h", out_valid, out_row, out_data, hold_row, hold_data); end
      end
      hold_q    = out_valid && !out_ready;
      hold_data = out_data;
      hold_row  = out_row;
      if (layer_done) n_done++;
      if (cfg_err)    n_cfg++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((busy || exp_out.size() != 0) && k < budget) begin
         tick();
         k++;
      end
      n_vec++;
      if (busy || exp_out.size() != 0 || exp_rd.size() != 0)
         begin n_err++; $display("FAIL drain_timeout: got busy %0b rows_left %0d expected idle and 0", busy, exp_out.size()); end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start_layer = '0; out_ready = 1'b0;
      tick(); tick();
      n_vec++;
      if ({rd_en, rd_layer, rd_row, out_valid, out_data, out_row, out_last, layer_done, busy, cfg_err} !== '0)
         begin n_err++; $display("FAIL reset_outputs: got nonzero outputs (busy %0b v %0b) expected all 0", busy, out_valid); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      n_rd = 0;
      push_layer(0);
      out_ready = 1'b1; start_layer = 0; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      n_vec++;
      if (n_rd != 2) begin n_err++; $display("FAIL mid_reset_reads: got %0d expected 2", n_rd); end
      reset = 1'b1;
      #1;
      n_vec++;
      if ({rd_en, rd_layer, rd_row, out_valid, out_data, out_row, out_last, layer_done, busy, cfg_err} !== '0)
         begin n_err++; $display("FAIL mid_reset_outputs: got busy %0b v %0b rd %0b expected all 0", busy, out_valid, rd_en); end
      exp_rd.delete(); exp_out.delete(); hold_q = 1'b0;
      tick(); tick();
      reset = 1'b0;
      for (int t = 0; t < 6; t++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL post_reset_idle: got v %0b busy %0b expected 0 0", out_valid, busy); end
      end
   endtask

   task automatic test_basic();
      logic [4:0] exp_b;
      n_rd = 0; n_done = 0;
      push_layer(1);
      out_ready = 1'b1; start_layer = 1; start = 1'b1;
      for (int t = 0; t <= 8; t++) begin
         exp_b = {(t >= 1 && t <= 3), (t >= 3 && t <= 5), (t == 5), (t == 6), (t >= 1 && t <= 6)};
         n_vec++;
         if ({rd_en, out_valid, out_last, layer_done, busy} !== exp_b)
            begin n_err++; $display("FAIL basic_cycle%0d: got rd/v/last/done/busy %b expected %b", t, {rd_en, out_valid, out_last, layer_done, busy}, exp_b); end
         tick();
         start = 1'b0;
      end
      n_vec++;
      if (exp_out.size() != 0 || n_done != 1 || n_rd != 3)
         begin n_err++; $display("FAIL basic_totals: got left %0d done %0d reads %0d expected 0 1 3", exp_out.size(), n_done, n_rd); end
   endtask

   task automatic test_backpressure();
      n_rd = 0; n_pop = 0;
      push_layer(2);
      out_ready = 1'b0; start_layer = 2; start = 1'b1;
      tick(); start = 1'b0;
      for (int t = 1; t <= 6; t++) tick();
      n_vec++;
      if (n_rd != 2 || rd_en !== 1'b0 || out_valid !== 1'b1 || out_row !== 32'd0)
         begin n_err++; $display("FAIL bp_stall: got reads %0d rd %0b v %0b row %0d expected 2 0 1 0", n_rd, rd_en, out_valid, out_row); end
      out_ready = 1'b1;
      wait_drain(20);
      n_vec++;
      if (n_pop != 3 || n_rd != 3)
         begin n_err++; $display("FAIL bp_totals: got pops %0d reads %0d expected 3 3", n_pop, n_rd); end
   endtask

   task automatic test_cfg_err();
      n_rd = 0; n_cfg = 0;
      out_ready = 1'b1; start_layer = LAYERS; start = 1'b1;
      tick(); start = 1'b0;
      n_vec++;
      if ({cfg_err, busy, rd_en} !== 3'b100)
         begin n_err++; $display("FAIL cfg_err_pulse: got err/busy/rd %b expected 100", {cfg_err, busy, rd_en}); end
      tick();
      n_vec++;
      if ({cfg_err, busy, rd_en} !== 3'b000)
         begin n_err++; $display("FAIL cfg_err_clear: got err/busy/rd %b expected 000", {cfg_err, busy, rd_en}); end
      n_cfg = 0;
      push_layer(0);
      start_layer = 0; start = 1'b1;
      tick();
      start_layer = 3; tick(); tick();
      start_layer = 9; tick();
      start = 1'b0;
      wait_drain(20);
      n_vec++;
      if (n_rd != 3 || n_cfg != 0)
         begin n_err++; $display("FAIL start_while_busy: got reads %0d cfg_err %0d expected 3 0", n_rd, n_cfg); end
   endtask

   task automatic test_toggle();
      int k = 1;
      n_pop = 0;
      push_layer(3);
      out_ready = 1'b1; start_layer = 3; start = 1'b1;
      tick(); start = 1'b0;
      while ((busy || exp_out.size() != 0) && k < 30) begin
         out_ready = (k % 2 == 0);
         tick();
         k++;
      end
      out_ready = 1'b1;
      n_vec++;
      if (n_pop != 3 || exp_out.size() != 0 || busy !== 1'b0)
         begin n_err++; $display("FAIL toggle_totals: got pops %0d left %0d busy %0b expected 3 0 0", n_pop, exp_out.size(), busy); end
   endtask

`ifdef FETCHER_AUTO_ADVANCE_EN
   task automatic test_auto_advance();
      n_rd = 0; n_done = 0;
      push_layer(2); push_layer(3);
      out_ready = 1'b1; start_layer = 2; start = 1'b1;
      tick(); start = 1'b0;
      for (int t = 1; t <= 7; t++) begin
         n_vec++;
         if (rd_en !== (t <= 6))
            begin n_err++; $display("FAIL auto_rd_cycle%0d: got %0b expected %0b", t, rd_en, (t <= 6)); end
         tick();
      end
      wait_drain(20);
      n_vec++;
      if (n_rd != 6 || n_done != 2)
         begin n_err++; $display("FAIL auto_totals: got reads %0d done %0d expected 6 2", n_rd, n_done); end
   endtask
`else
   task automatic test_last_layer();
      n_rd = 0; n_done = 0;
      push_layer(LAYERS - 1);
      out_ready = 1'b1; start_layer = LAYERS - 1; start = 1'b1;
      tick(); start = 1'b0;
      wait_drain(20);
      n_vec++;
      if (n_rd != SIZE || n_done != 1)
         begin n_err++; $display("FAIL last_layer_totals: got reads %0d done %0d expected %0d 1", n_rd, n_done, SIZE); end
   endtask
`endif

   initial begin
      test_reset();
      test_mid_reset();
      test_basic();
      test_backpressure();
      test_cfg_err();
      test_toggle();
`ifdef FETCHER_AUTO_ADVANCE_EN
      test_auto_advance();
`else
      test_last_layer();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
